// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_ctrl
//  Description : Scan-code controller that sits behind the PS/2 receiver FIFO.
//                It pops bytes with the ready / nextdata_n handshake, decodes
//                the set-2 prefixes (0xE0 = extended, 0xF0 = break), and emits
//                one key event for each complete sequence. It also tracks the
//                held key, a wrapping key-press counter, a saturating
//                dropped-byte counter and a sticky overflow flag.
//  Options     : `define PS2_KEY_REPEAT_FILTER_EN to suppress typematic
//                auto-repeat make events for the key that is already held.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_key_ctrl #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_data,
  input  logic             i_ready,
  input  logic             i_overflow,
  output logic             o_nextdata_n,
  output logic             o_key_valid,
  output logic             o_key_make,
  output logic             o_key_ext,
  output logic [7:0]       o_key_code,
  output logic             o_key_held,
  output logic [7:0]       o_held_code,
  output logic [CNT_W-1:0] o_press_cnt,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_ovf_seen
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_POP    = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;

  localparam logic [7:0] C_PFX_EXT = 8'hE0;
  localparam logic [7:0] C_PFX_BRK = 8'hF0;
  localparam logic [7:0] C_BAD_LO  = 8'h00;
  localparam logic [7:0] C_BAD_HI  = 8'hFF;

  localparam logic [ERR_W-1:0] C_ERR_MAX = {ERR_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [ERR_W-1:0] C_ERR_ONE = ERR_W'(1);

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,      state_d;
  logic [7:0]       byte_q,       byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             ext_q,        ext_d;
  logic             brk_q,        brk_d;
  logic             key_valid_q,  key_valid_d;
  logic             key_make_q,   key_make_d;
  logic             key_ext_q,    key_ext_d;
  logic [7:0]       key_code_q,   key_code_d;
  logic             key_held_q,   key_held_d;
  logic [7:0]       held_code_q,  held_code_d;
  logic             held_ext_q,   held_ext_d;
  logic [CNT_W-1:0] press_cnt_q,  press_cnt_d;
  logic [ERR_W-1:0] err_cnt_q,    err_cnt_d;
  logic             ovf_seen_q,   ovf_seen_d;

  // Decode helpers
  logic same_as_held;   // latched code/ext matches the currently held key
  logic suppress_make;  // make event to be swallowed as auto-repeat

  // The latched byte names the same physical key as the one being held.
  assign same_as_held = key_held_q &&
                        (byte_q == held_code_q) &&
                        (ext_q  == held_ext_q);

  // Auto-repeat filter: only active when the build enables it.
  always_comb begin
`ifdef PS2_KEY_REPEAT_FILTER_EN
    suppress_make = same_as_held;
`else
    suppress_make = 1'b0;
`endif
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  // State register; reset abandons any pop in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  // Fixed IDLE -> POP -> DECODE -> IDLE walk, gated only by FIFO ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_ready) begin
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM output / datapath logic
  // --------------------------------------------------------------------------
  // Computes the next value of every registered output and internal flag.
  // The pop strobe is produced one cycle ahead so that the registered copy
  // is low exactly while the FSM sits in POP.
  always_comb begin
    byte_d       = byte_q;
    nextdata_n_d = 1'b1;
    ext_d        = ext_q;
    brk_d        = brk_q;
    key_valid_d  = 1'b0;
    key_make_d   = key_make_q;
    key_ext_d    = key_ext_q;
    key_code_d   = key_code_q;
    key_held_d   = key_held_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    press_cnt_d  = press_cnt_q;
    err_cnt_d    = err_cnt_q;
    ovf_seen_d   = ovf_seen_q | i_overflow;

    case (state_q)
      ST_IDLE: begin
        // Capture the FIFO head and strobe the pop for the following cycle.
        if (i_ready) begin
          byte_d       = i_data;
          nextdata_n_d = 1'b0;
        end
      end

      ST_DECODE: begin
        case (byte_q)
          C_PFX_EXT: begin
            ext_d = 1'b1;
          end
          C_PFX_BRK: begin
            brk_d = 1'b1;
          end
          C_BAD_LO, C_BAD_HI: begin
            // Receiver error / buffer-overrun codes: drop and restart the
            // sequence so a stale prefix cannot attach to the next key.
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (err_cnt_q != C_ERR_MAX) begin
              err_cnt_d = err_cnt_q + C_ERR_ONE;
            end
          end
          default: begin
            // Final code: sequence complete, prefixes are consumed.
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (!brk_q) begin
              if (!suppress_make) begin
                key_valid_d = 1'b1;
                key_make_d  = 1'b1;
                key_ext_d   = ext_q;
                key_code_d  = byte_q;
                key_held_d  = 1'b1;
                held_code_d = byte_q;
                held_ext_d  = ext_q;
                press_cnt_d = press_cnt_q + C_CNT_ONE;
              end
            end else begin
              key_valid_d = 1'b1;
              key_make_d  = 1'b0;
              key_ext_d   = ext_q;
              key_code_d  = byte_q;
              // Only releasing the held key itself clears the held state;
              // the last held code stays visible for downstream logic.
              if (same_as_held) begin
                key_held_d = 1'b0;
              end
            end
          end
        endcase
      end

      default: begin
        // POP: strobe already issued; nothing else changes.
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output and datapath registers
  // --------------------------------------------------------------------------
  // Registers for the datapath; reset clears everything and idles the strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_q       <= 8'h00;
      nextdata_n_q <= 1'b1;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      key_valid_q  <= 1'b0;
      key_make_q   <= 1'b0;
      key_ext_q    <= 1'b0;
      key_code_q   <= 8'h00;
      key_held_q   <= 1'b0;
      held_code_q  <= 8'h00;
      held_ext_q   <= 1'b0;
      press_cnt_q  <= '0;
      err_cnt_q    <= '0;
      ovf_seen_q   <= 1'b0;
    end else begin
      byte_q       <= byte_d;
      nextdata_n_q <= nextdata_n_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      key_valid_q  <= key_valid_d;
      key_make_q   <= key_make_d;
      key_ext_q    <= key_ext_d;
      key_code_q   <= key_code_d;
      key_held_q   <= key_held_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      press_cnt_q  <= press_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ovf_seen_q   <= ovf_seen_d;
    end
  end

  // --------------------------------------------------------------------------
  // Port mapping
  // --------------------------------------------------------------------------
  assign o_nextdata_n = nextdata_n_q;
  assign o_key_valid  = key_valid_q;
  assign o_key_make   = key_make_q;
  assign o_key_ext    = key_ext_q;
  assign o_key_code   = key_code_q;
  assign o_key_held   = key_held_q;
  assign o_held_code  = held_code_q;
  assign o_press_cnt  = press_cnt_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_ovf_seen   = ovf_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_ctrl
//  Description : Directed self-checking bench for ps2_key_ctrl. A small queue
//                stands in for the receiver FIFO and a monitor collects key
//                events as {make, ext, code}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_key_ctrl;

  localparam int CNT_W = 8;
  localparam int ERR_W = 4;

`ifdef PS2_KEY_REPEAT_FILTER_EN
  localparam int REP_MAKES = 1;
`else
  localparam int REP_MAKES = 3;
`endif

  logic             i_clk;
  logic             i_rst;
  logic [7:0]       i_data;
  logic             i_ready;
  logic             i_overflow;
  logic             o_nextdata_n;
  logic             o_key_valid;
  logic             o_key_make;
  logic             o_key_ext;
  logic [7:0]       o_key_code;
  logic             o_key_held;
  logic [7:0]       o_held_code;
  logic [CNT_W-1:0] o_press_cnt;
  logic [ERR_W-1:0] o_err_cnt;
  logic             o_ovf_seen;

  ps2_key_ctrl #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_ready      (i_ready),
    .i_overflow   (i_overflow),
    .o_nextdata_n (o_nextdata_n),
    .o_key_valid  (o_key_valid),
    .o_key_make   (o_key_make),
    .o_key_ext    (o_key_ext),
    .o_key_code   (o_key_code),
    .o_key_held   (o_key_held),
    .o_held_code  (o_held_code),
    .o_press_cnt  (o_press_cnt),
    .o_err_cnt    (o_err_cnt),
    .o_ovf_seen   (o_ovf_seen)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int exp_press = 0;

  logic [7:0] fifo_q[$];
  logic [9:0] ev_q[$];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Receiver FIFO model: pops when the strobe is seen low, head always visible.
  initial begin
    i_ready = 1'b0;
    i_data  = 8'h00;
    forever begin
      @(negedge i_clk);
      if (o_nextdata_n === 1'b0 && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
      end
      i_ready = (fifo_q.size() != 0);
      i_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Event monitor.
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_key_valid === 1'b1) begin
        ev_q.push_back({o_key_make, o_key_ext, o_key_code});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input int idx, input logic [9:0] exp);
    logic [31:0] obs;
    obs = (idx < ev_q.size()) ? {22'd0, ev_q[idx]} : 32'hFFFF_FFFF;
    chk(tag, obs, {22'd0, exp});
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (fifo_q.size() != 0 && n < 4000) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain", fifo_q.size(), 0);
    repeat (4) @(negedge i_clk);
  endtask

  initial begin
    i_rst      = 1'b1;
    i_overflow = 1'b0;
    push(8'h1C);

    // ---------------- Reset with FIFO ready -------------------------------
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_nextdata_n", o_nextdata_n, 1);
    chk("rst_valid",      o_key_valid, 0);
    chk("rst_make",       o_key_make, 0);
    chk("rst_code",       o_key_code, 0);
    chk("rst_held",       o_key_held, 0);
    chk("rst_held_code",  o_held_code, 0);
    chk("rst_press",      o_press_cnt, 0);
    chk("rst_err",        o_err_cnt, 0);
    chk("rst_ovf",        o_ovf_seen, 0);
    i_rst = 1'b0;
    // First cycle after reset is IDLE (above), the next is POP.
    @(negedge i_clk);
    chk("first_pop", o_nextdata_n, 0);
    @(negedge i_clk);
    chk("pop_one_cycle", o_nextdata_n, 1);
    wait_done();
    exp_press = 1;
    chk("mk_count", ev_q.size(), 1);
    chk_ev("mk_ev", 0, 10'h21C);
    chk("mk_press", o_press_cnt, exp_press);
    chk("mk_held", o_key_held, 1);
    chk("mk_held_code", o_held_code, 8'h1C);

    // ---------------- Break ------------------------------------------------
    ev_q.delete();
    push(8'hF0); push(8'h1C);
    wait_done();
    chk("brk_count", ev_q.size(), 1);
    chk_ev("brk_ev", 0, 10'h01C);
    chk("brk_held", o_key_held, 0);
    chk("brk_held_code", o_held_code, 8'h1C);

    // ---------------- Extended make / break --------------------------------
    ev_q.delete();
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    wait_done();
    exp_press++;
    chk("ext_count", ev_q.size(), 2);
    chk_ev("ext_make", 0, 10'h375);
    chk_ev("ext_break", 1, 10'h175);
    chk("ext_held", o_key_held, 0);
    chk("ext_press", o_press_cnt, exp_press);

    // Stray non-extended break while the extended key is held.
    ev_q.delete();
    push(8'hE0); push(8'h75); push(8'hF0); push(8'h75);
    wait_done();
    exp_press++;
    chk("stray_count", ev_q.size(), 2);
    chk_ev("stray_ev", 1, 10'h075);
    chk("stray_held", o_key_held, 1);
    // Break prefix before extended prefix releases it.
    ev_q.delete();
    push(8'hF0); push(8'hE0); push(8'h75);
    wait_done();
    chk_ev("fe_break", 0, 10'h175);
    chk("fe_held", o_key_held, 0);

    // ---------------- Auto-repeat ------------------------------------------
    ev_q.delete();
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    wait_done();
    exp_press += REP_MAKES;
    chk("rep_count", ev_q.size(), REP_MAKES + 1);
    chk_ev("rep_first", 0, 10'h21C);
    chk_ev("rep_break", REP_MAKES, 10'h01C);
    chk("rep_press", o_press_cnt, exp_press);
    chk("rep_held", o_key_held, 0);

    // ---------------- Errors -----------------------------------------------
    ev_q.delete();
    push(8'h00); push(8'hFF);
    for (int i = 0; i < 17; i++) push(8'h00);
    wait_done();
    chk("err_count_ev", ev_q.size(), 0);
    chk("err_sat", o_err_cnt, 15);
    chk("err_press", o_press_cnt, exp_press);

    // A dropped byte discards a pending extended prefix.
    push(8'hE0); push(8'h00); push(8'h1C); push(8'hF0); push(8'h1C);
    wait_done();
    exp_press++;
    chk("errpfx_count", ev_q.size(), 2);
    chk_ev("errpfx_make", 0, 10'h21C);
    chk("errpfx_sat", o_err_cnt, 15);

    // ---------------- Overflow sticky --------------------------------------
    i_overflow = 1'b1;
    @(negedge i_clk);
    i_overflow = 1'b0;
    @(negedge i_clk);
    chk("ovf_set", o_ovf_seen, 1);
    repeat (5) @(negedge i_clk);
    chk("ovf_sticky", o_ovf_seen, 1);

    // ---------------- Reset, then counter wrap ------------------------------
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst2_ovf", o_ovf_seen, 0);
    chk("rst2_press", o_press_cnt, 0);
    chk("rst2_err", o_err_cnt, 0);
    for (int i = 0; i < 255; i++) begin
      push(8'h2A); push(8'hF0); push(8'h2A);
    end
    wait_done();
    chk("wrap_255", o_press_cnt, 255);
    push(8'h2A); push(8'hF0); push(8'h2A);
    wait_done();
    chk("wrap_0", o_press_cnt, 0);
    chk("wrap_held", o_key_held, 0);

    // ---------------- Reset during POP -------------------------------------
    ev_q.delete();
    push(8'h1C);
    begin
      int n;
      n = 0;
      while (o_nextdata_n !== 1'b0 && n < 20) begin
        @(negedge i_clk);
        n++;
      end
    end
    chk("midpop_found", o_nextdata_n, 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("midpop_nextdata_n", o_nextdata_n, 1);
    chk("midpop_valid", o_key_valid, 0);
    repeat (8) @(negedge i_clk);
    chk("midpop_no_event", ev_q.size(), 0);
    chk("midpop_press", o_press_cnt, 0);
    chk("midpop_held", o_key_held, 0);
    chk("midpop_idle_strobe", o_nextdata_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
